fetch_stage: RTL
================

Name: fetch_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register. Directly upstream of the control unit.
- Holds the PC and drives the instruction-memory address.
- Latches the fetched 16-bit instruction and presents opcode[3:0] (instr[15:12]) to control.
- Handles hazard stalls, branch/jump redirects with squash, and the HALT opcode (4'b1111).

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset
NOP_INSTR, 16'h0000, bubble encoding inserted into IF/ID on reset/squash
HALT_OP, 4'b1111, opcode that freezes fetch

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-low reset
imem_addr  output  16  byte address to instruction memory (combinational read)
imem_data  input  16  instruction word at imem_addr, valid same cycle
stall  input  1  hazard unit: hold PC and IF/ID
redirect  input  1  taken branch/jump resolved downstream
redirect_pc  input  16  new PC target; bit 0 ignored
ifid_instr  output  16  registered instruction
ifid_pc_plus2  output  16  registered PC+2 of that instruction
ifid_valid  output  1  IF/ID holds a real instruction
opcode  output  4  ifid_instr[15:12], fed to control
halted  output  1  fetch frozen on HALT
fetch_count  output  16  number of valid instructions loaded into IF/ID

Behaviour:
- Reset (rst=0, asynchronous) takes effect immediately:
  - pc=RESET_PC; state=RUN
  - ifid_instr=NOP_INSTR, ifid_pc_plus2=0, ifid_valid=0
  - halted=0, fetch_count=0
- imem_addr = pc at all times.
- States: RUN, HALTED. halted = (state==HALTED).
- Per rising edge, priority redirect > stall > normal:
  - redirect=1 (either state):
    - pc <= {redirect_pc[15:1],1'b0}
    - IF/ID <= bubble (NOP_INSTR, valid=0); state <= RUN
    - fetch_count unchanged
    - Overrides stall and squashes a HALT already in IF/ID.
  - RUN, stall=1: pc, IF/ID and fetch_count hold.
  - RUN, normal:
    - ifid_instr <= imem_data; ifid_pc_plus2 <= pc+2; ifid_valid <= 1
    - fetch_count <= fetch_count+1
    - If imem_data[15:12]==HALT_OP: pc holds and state <= HALTED. Otherwise pc <= pc+2.
  - HALTED, no redirect: everything holds. The HALT instruction stays in IF/ID with valid=1. stall has no effect.
- Latency: the instruction at address A appears on ifid_instr/opcode one cycle after pc==A.
- Arithmetic: pc+2 is a 16-bit add with wrap-around, so 16'hFFFE -> 16'h0000. fetch_count wraps 16'hFFFF -> 0.
- Reset asserted mid-stall, mid-redirect or in HALTED returns to the reset values above on the same edge of rst, with no clock needed.
- First fetch after reset release: the first rising edge with rst=1 loads mem[RESET_PC].

Test Plan:
- Reset, then free-run with mem[0..6] = 16'h0123, 16'h1456, 16'h2789, 16'hC000 → ifid_instr follows one cycle behind pc; opcode sequence 0,1,2,C; ifid_pc_plus2 = 2,4,6,8; fetch_count = 4.
- Stall asserted for 3 cycles while pc=4 → pc stays 4; ifid_instr stays 16'h1456; fetch_count frozen; resumes with 16'h2789.
- redirect=1 with redirect_pc=16'h0041 while stall=1 → pc=16'h0040; ifid_valid=0; opcode=0 (bubble); next cycle loads mem[16'h40].
- mem[8]=16'hF000 → after the load, halted=1, opcode=4'b1111, pc stays 8 for 10+ cycles, fetch_count stops. Then redirect to 16'h0010 → halted=0, bubble, fetch resumes at 16'h10.
- pc=16'hFFFE with mem[FFFE]=16'h0001 → next pc=16'h0000 and ifid_pc_plus2=16'h0000.
- Assert rst low asynchronously mid-cycle while HALTED with fetch_count=5 → outputs return to reset values immediately, without waiting for clk.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Holds the PC, handles stall, redirect-with-squash and HALT freezing.
module fetch_stage #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0000,
  parameter logic [3:0]  HALT_OP   = 4'b1111
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic [15:0] ifid_instr,
  output logic [15:0] ifid_pc_plus2,
  output logic        ifid_valid,
  output logic [3:0]  opcode,
  output logic        halted,
  output logic [15:0] fetch_count
);

  typedef enum logic [0:0] {StRun, StHalted} state_e;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] pc_plus2_q, pc_plus2_d;
  logic        valid_q, valid_d;
  logic [15:0] count_q, count_d;
  logic [15:0] pc_inc;

  assign pc_inc = pc_q + 16'd2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StRun;
      pc_q       <= RESET_PC;
      instr_q    <= NOP_INSTR;
      pc_plus2_q <= 16'h0000;
      valid_q    <= 1'b0;
      count_q    <= 16'h0000;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      pc_plus2_q <= pc_plus2_d;
      valid_q    <= valid_d;
      count_q    <= count_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    pc_plus2_d = pc_plus2_q;
    valid_d    = valid_q;
    count_d    = count_q;
    if (redirect) begin
      // Redirect beats stall and also squashes a HALT sitting in IF/ID.
      state_d    = StRun;
      pc_d       = {redirect_pc[15:1], 1'b0};
      instr_d    = NOP_INSTR;
      pc_plus2_d = 16'h0000;
      valid_d    = 1'b0;
    end else if (state_q == StRun && !stall) begin
      instr_d    = imem_data;
      pc_plus2_d = pc_inc;
      valid_d    = 1'b1;
      count_d    = count_q + 16'd1;
      if (imem_data[15:12] == HALT_OP) begin
        state_d = StHalted;
      end else begin
        pc_d = pc_inc;
      end
    end
  end

  assign imem_addr     = pc_q;
  assign ifid_instr    = instr_q;
  assign ifid_pc_plus2 = pc_plus2_q;
  assign ifid_valid    = valid_q;
  assign opcode        = instr_q[15:12];
  assign halted        = (state_q == StHalted);
  assign fetch_count   = count_q;

endmodule
